// File: rtl/flag_tex_loader.sv
// Streams one 60x120 card image from a valid/ready pixel source into the
// left or right half of the 120-word-pitch HUD flag-texture BRAM.
module flag_tex_loader #(
  parameter int MEM_W = 120,
  parameter int IMG_W = 60,
  parameter int IMG_H = 120,
  parameter int PIX_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel_right,
  input  logic             abort,
  input  logic             s_valid,
  input  logic [PIX_W-1:0] s_data,
  output logic             s_ready,
  output logic             we,
  output logic [13:0]      waddr,
  output logic [PIX_W-1:0] wdata,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [5:0]  X_LAST   = 6'(IMG_W - 1);
  localparam logic [6:0]  Y_LAST   = 7'(IMG_H - 1);
  localparam logic [13:0] COL_OFF  = 14'(IMG_W);
  // Jump from the last column of one row to the first column of the next.
  localparam logic [13:0] ROW_STEP = 14'(MEM_W - IMG_W + 1);

  state_t      state, state_nxt;
  logic [5:0]  x;
  logic [6:0]  y;
  logic [13:0] addr;
  logic        accept;
  logic        last_beat;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last_beat = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        s_ready   = !abort;
        accept    = s_valid && !abort;
        last_beat = accept && (x == X_LAST) && (y == Y_LAST);
        if (abort)          state_nxt = IDLE;
        else if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x     <= '0;
      y     <= '0;
      addr  <= '0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= accept;
      if (state == IDLE && start) begin
        x    <= '0;
        y    <= '0;
        addr <= sel_right ? COL_OFF : '0;
      end
      if (accept) begin
        waddr <= addr;
        wdata <= s_data;
        if (x != X_LAST) begin
          x    <= x + 6'd1;
          addr <= addr + 14'd1;
        end else begin
          x    <= '0;
          y    <= y + 7'd1;
          addr <= addr + ROW_STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_flag_tex_loader.sv
// Randomized bench for flag_tex_loader: logs every BRAM write and checks the
// log against addresses computed from row/column arithmetic.
module tb_flag_tex_loader;

  localparam int MEM_W = 120;
  localparam int IMG_W = 60;
  localparam int IMG_H = 120;
  localparam int PIX_W = 12;
  localparam int NPIX  = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sel_right = 1'b0;
  logic             abort = 1'b0;
  logic             s_valid = 1'b0;
  logic [PIX_W-1:0] s_data = '0;
  logic             s_ready;
  logic             we;
  logic [13:0]      waddr;
  logic [PIX_W-1:0] wdata;
  logic             busy;
  logic             done;

  int total = 0;
  int bad = 0;

  flag_tex_loader #(.MEM_W(MEM_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel_right(sel_right), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .we(we), .waddr(waddr),
    .wdata(wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // write log, filled on the falling edge
  int aq[$];
  int dq[$];
  int done_cnt = 0;
  int done_we = 0;

  always @(negedge clk) begin
    if (we) begin
      aq.push_back(int'(waddr));
      dq.push_back(int'(wdata));
    end
    if (done) begin
      done_cnt++;
      if (we) done_we++;
    end
  end

  task automatic clear_log();
    aq.delete();
    dq.delete();
    done_cnt = 0;
    done_we = 0;
  endtask

  // reference placement of write i for a card whose first column is off
  function automatic int exp_addr(input int i, input int off);
    return (i / IMG_W) * MEM_W + (i % IMG_W) + off;
  endfunction

  function automatic int seq_errors(input int off);
    int e = 0;
    for (int i = 0; i < aq.size(); i++) begin
      if (aq[i] != exp_addr(i, off)) e++;
      if (dq[i] != (i % 4096)) e++;
    end
    return e;
  endfunction

  // Call at posedge+1 with the DUT in LOAD. Feeds pixels 0.. with pixel index
  // as data until n beats are accepted; tracks we against the previous cycle's
  // acceptance. Returns at posedge+1 with s_valid low.
  task automatic run_beats(input int n, input int pct, input bit poke_start,
                           output int got, output int we_err, output bit timeout);
    int  cyc = 0;
    bit  prev_acc = 1'b0;
    got = 0;
    we_err = 0;
    timeout = 1'b0;
    while (got < n) begin
      if (cyc > n * 20 + 100) begin
        timeout = 1'b1;
        break;
      end
      s_valid = ($urandom_range(99) < pct);
      s_data  = PIX_W'(got);
      if (poke_start) begin
        start     = $urandom_range(1);
        sel_right = $urandom_range(1);
      end
      @(negedge clk);
      if (we !== prev_acc) we_err++;
      prev_acc = s_valid && s_ready;
      if (prev_acc) got++;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic begin_load(input bit right);
    start = 1'b1;
    sel_right = right;
    @(posedge clk); #1;
    start = 1'b0;
    sel_right = ~right;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (we !== 1'b0)      begin bad++; $display("FAIL reset_we got=%b exp=0", we); end
    total++; if (waddr !== 14'd0)  begin bad++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
    total++; if (wdata !== '0)     begin bad++; $display("FAIL reset_wdata got=%0d exp=0", wdata); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(2);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL idle_s_ready got=%b exp=0", s_ready); end
  endtask

  task automatic test_left_continuous();
    int got, we_err, col_bad;
    bit to;
    clear_log();
    begin_load(1'b0);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL left_ready_after_start got=%b exp=1", s_ready); end
    run_beats(NPIX, 100, 1'b0, got, we_err, to);
    idle_cycles(3);
    total++; if (to) begin bad++; $display("FAIL left_timeout accepted=%0d exp=%0d", got, NPIX); end
    total++; if (aq.size() != NPIX) begin bad++; $display("FAIL left_write_count got=%0d exp=%0d", aq.size(), NPIX); end
    if (aq.size() == NPIX) begin
      total++; if (aq[0] != 0)      begin bad++; $display("FAIL left_first_addr got=%0d exp=0", aq[0]); end
      total++; if (dq[0] != 0)      begin bad++; $display("FAIL left_first_data got=%0d exp=0", dq[0]); end
      total++; if (aq[59] != 59)    begin bad++; $display("FAIL left_60th_addr got=%0d exp=59", aq[59]); end
      total++; if (aq[60] != 120)   begin bad++; $display("FAIL left_61st_addr got=%0d exp=120", aq[60]); end
      total++; if (aq[NPIX-1] != 14339) begin bad++; $display("FAIL left_last_addr got=%0d exp=14339", aq[NPIX-1]); end
      total++; if (dq[NPIX-1] != 7199 % 4096) begin bad++; $display("FAIL left_last_data got=%0d exp=%0d", dq[NPIX-1], 7199 % 4096); end
    end
    col_bad = 0;
    foreach (aq[i]) if ((aq[i] % MEM_W) >= IMG_W) col_bad++;
    total++; if (col_bad != 0) begin bad++; $display("FAIL left_column_range got=%0d exp=0 out-of-half writes", col_bad); end
    total++; if (seq_errors(0) != 0) begin bad++; $display("FAIL left_sequence got=%0d exp=0 errors", seq_errors(0)); end
    total++; if (we_err != 0) begin bad++; $display("FAIL left_we_timing got=%0d exp=0 errors", we_err); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL left_done_count got=%0d exp=1", done_cnt); end
    total++; if (done_we != 1) begin bad++; $display("FAIL left_done_with_last_we got=%0d exp=1", done_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL left_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_right_continuous();
    int got, we_err;
    bit to;
    clear_log();
    begin_load(1'b1);
    run_beats(NPIX, 100, 1'b0, got, we_err, to);
    idle_cycles(3);
    total++; if (aq.size() != NPIX) begin bad++; $display("FAIL right_write_count got=%0d exp=%0d", aq.size(), NPIX); end
    if (aq.size() == NPIX) begin
      total++; if (aq[0] != 60)    begin bad++; $display("FAIL right_first_addr got=%0d exp=60", aq[0]); end
      total++; if (aq[59] != 119)  begin bad++; $display("FAIL right_60th_addr got=%0d exp=119", aq[59]); end
      total++; if (aq[60] != 180)  begin bad++; $display("FAIL right_61st_addr got=%0d exp=180", aq[60]); end
      total++; if (aq[NPIX-1] != 14399) begin bad++; $display("FAIL right_last_addr got=%0d exp=14399", aq[NPIX-1]); end
    end
    total++; if (seq_errors(IMG_W) != 0) begin bad++; $display("FAIL right_sequence got=%0d exp=0 errors", seq_errors(IMG_W)); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL right_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_random_gaps();
    int got, we_err;
    bit to;
    clear_log();
    begin_load(1'b0);
    run_beats(NPIX, 50, 1'b0, got, we_err, to);
    idle_cycles(3);
    total++; if (to) begin bad++; $display("FAIL gaps_timeout accepted=%0d exp=%0d", got, NPIX); end
    total++; if (aq.size() != NPIX) begin bad++; $display("FAIL gaps_write_count got=%0d exp=%0d", aq.size(), NPIX); end
    total++; if (seq_errors(0) != 0) begin bad++; $display("FAIL gaps_sequence got=%0d exp=0 errors", seq_errors(0)); end
    total++; if (we_err != 0) begin bad++; $display("FAIL gaps_we_in_gap got=%0d exp=0 errors", we_err); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL gaps_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_abort();
    int got, we_err;
    bit to;
    clear_log();
    begin_load(1'b0);
    run_beats(100, 70, 1'b0, got, we_err, to);
    abort = 1'b1;
    s_valid = 1'b1;
    s_data = PIX_W'(100);
    @(negedge clk);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL abort_s_ready got=%b exp=0", s_ready); end
    @(posedge clk); #1;
    abort = 1'b0;
    s_valid = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_to_idle busy=%b exp=0", busy); end
    idle_cycles(3);
    total++; if (aq.size() != 100) begin bad++; $display("FAIL abort_write_count got=%0d exp=100", aq.size()); end
    total++; if (seq_errors(0) != 0) begin bad++; $display("FAIL abort_sequence got=%0d exp=0 errors", seq_errors(0)); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    // abort while idle must not disturb a fresh load
    abort = 1'b1;
    idle_cycles(1);
    abort = 1'b0;
    clear_log();
    begin_load(1'b0);
    run_beats(5, 100, 1'b0, got, we_err, to);
    idle_cycles(1);
    total++; if (aq.size() < 1 || aq[0] != 0) begin bad++; $display("FAIL abort_restart_addr got=%0d exp=0", aq.size() > 0 ? aq[0] : -1); end
    abort = 1'b1;
    idle_cycles(1);
    abort = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_start_during_load();
    int got, we_err;
    bit to;
    clear_log();
    begin_load(1'b1);
    run_beats(NPIX, 80, 1'b1, got, we_err, to);
    idle_cycles(3);
    total++; if (aq.size() != NPIX) begin bad++; $display("FAIL restart_write_count got=%0d exp=%0d", aq.size(), NPIX); end
    total++; if (seq_errors(IMG_W) != 0) begin bad++; $display("FAIL restart_sequence got=%0d exp=0 errors", seq_errors(IMG_W)); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL restart_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_midload();
    int got, we_err;
    bit to;
    clear_log();
    begin_load(1'b0);
    run_beats(3000, 100, 1'b0, got, we_err, to);
    rst_n = 1'b0;
    s_valid = 1'b1;
    s_data = PIX_W'(3000);
    @(posedge clk); #1;
    total++; if (we !== 1'b0)      begin bad++; $display("FAIL rst_mid_we got=%b exp=0", we); end
    total++; if (waddr !== 14'd0)  begin bad++; $display("FAIL rst_mid_waddr got=%0d exp=0", waddr); end
    total++; if (wdata !== '0)     begin bad++; $display("FAIL rst_mid_wdata got=%0d exp=0", wdata); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_s_ready got=%b exp=0", s_ready); end
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(4);
    s_valid = 1'b0;
    total++; if (aq.size() != 3000) begin bad++; $display("FAIL rst_mid_write_count got=%0d exp=3000", aq.size()); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_left_continuous();
    test_right_continuous();
    test_random_gaps();
    test_abort();
    test_start_during_load();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
